// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter family.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int UART_DATA_W     = 8;
    localparam int TIMEOUT_CYC_DEF = 65536;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: the first requester strictly after
// rr_ptr (wrapping modulo N_REQ) wins. rr_ptr itself is checked last.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;

    // Walk candidates in priority order and latch the first requesting one.
    always_comb begin
        pick_oh  = {N_REQ{1'b0}};
        pick_idx = {IDX_W{1'b0}};
        found_s  = 1'b0;
        cand_s   = {IDX_W{1'b0}};
        hit_s    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s           = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            hit_s            = !found_s && req[cand_s];
            pick_oh[cand_s]  = pick_oh[cand_s] | hit_s;
            pick_idx         = hit_s ? cand_s : pick_idx;
            found_s          = found_s | hit_s;
        end
        any_req = |req;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and byte sequencer sharing one 8N1 UART transmitter
// among N_REQ requesters, one whole packet per grant.
// Optional feature: define UART_ARB_TIMEOUT_EN to abandon a byte whose
// tx_done rise does not arrive within TIMEOUT_CYC cycles (pulses err).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             last,
    input  logic [UART_DATA_W*N_REQ-1:0] din,
    output logic [N_REQ-1:0]             ack,
    output logic [N_REQ-1:0]             gnt,
    output logic                         busy,
    output logic                         trmt,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_done,
    output logic                         err
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t             state_r, state_nxt_s;
    logic [N_REQ-1:0]       gnt_r, gnt_nxt_s;
    logic [N_REQ-1:0]       ack_r, ack_nxt_s;
    logic                   trmt_r, trmt_nxt_s;
    logic                   busy_r;
    logic                   err_r, err_nxt_s;
    logic [UART_DATA_W-1:0] tx_data_r, tx_data_nxt_s;
    logic                   last_q_r, last_q_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0]       owner_r, owner_nxt_s;
    logic                   tx_done_q_r;
    logic                   done_rise_s;

    logic [N_REQ-1:0]       pick_oh_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   any_req_s;
    logic                   owner_req_s;
    logic                   owner_last_s;
    logic [UART_DATA_W-1:0] owner_data_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] timer_r, timer_nxt_s;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_r),
        .pick_oh  (pick_oh_s),
        .pick_idx (pick_idx_s),
        .any_req  (any_req_s)
    );

    // Only the rising edge of tx_done marks a finished frame; the level
    // stays high between frames.
    assign done_rise_s = tx_done & ~tx_done_q_r;

    // Select the current owner's req/last/byte through the one-hot grant.
    always_comb begin
        owner_req_s  = |(req & gnt_r);
        owner_last_s = |(last & gnt_r);
        owner_data_s = {UART_DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            owner_data_s = gnt_r[i] ? din[i*UART_DATA_W +: UART_DATA_W] : owner_data_s;
        end
    end

    // Next-state and next-output logic for the IDLE/SEND/WAIT sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_nxt_s     = gnt_r;
        ack_nxt_s     = {N_REQ{1'b0}};
        trmt_nxt_s    = 1'b0;
        err_nxt_s     = 1'b0;
        tx_data_nxt_s = tx_data_r;
        last_q_nxt_s  = last_q_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        owner_nxt_s   = owner_r;
`ifdef UART_ARB_TIMEOUT_EN
        timer_nxt_s   = timer_r;
`endif
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt_nxt_s   = pick_oh_s;
                    owner_nxt_s = pick_idx_s;
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (owner_req_s) begin
                    trmt_nxt_s    = 1'b1;
                    ack_nxt_s     = gnt_r;
                    tx_data_nxt_s = owner_data_s;
                    last_q_nxt_s  = owner_last_s;
                    state_nxt_s   = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    timer_nxt_s   = {TMR_W{1'b0}};
`endif
                end else begin
                    // Requester abandoned the packet: release and rotate.
                    gnt_nxt_s    = {N_REQ{1'b0}};
                    rr_ptr_nxt_s = owner_r;
                    state_nxt_s  = IDLE;
                end
            end
            WAIT: begin
                if (done_rise_s) begin
                    if (last_q_r) begin
                        gnt_nxt_s    = {N_REQ{1'b0}};
                        rr_ptr_nxt_s = owner_r;
                        state_nxt_s  = IDLE;
                    end else begin
                        state_nxt_s  = SEND;
                    end
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (timer_r == TMR_LAST) begin
                        err_nxt_s    = 1'b1;
                        gnt_nxt_s    = {N_REQ{1'b0}};
                        rr_ptr_nxt_s = owner_r;
                        state_nxt_s  = IDLE;
                    end else begin
                        timer_nxt_s  = timer_r + TMR_W'(1);
                    end
`else
                    state_nxt_s = WAIT;
`endif
                end
            end
            default: begin
                gnt_nxt_s   = {N_REQ{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= {N_REQ{1'b0}};
            ack_r       <= {N_REQ{1'b0}};
            trmt_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            tx_data_r   <= {UART_DATA_W{1'b0}};
            last_q_r    <= 1'b0;
            rr_ptr_r    <= IDX_W'(N_REQ - 1);
            owner_r     <= {IDX_W{1'b0}};
            tx_done_q_r <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timer_r     <= {TMR_W{1'b0}};
`endif
        end else begin
            state_r     <= state_nxt_s;
            gnt_r       <= gnt_nxt_s;
            ack_r       <= ack_nxt_s;
            trmt_r      <= trmt_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            err_r       <= err_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            last_q_r    <= last_q_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            owner_r     <= owner_nxt_s;
            tx_done_q_r <= tx_done;
`ifdef UART_ARB_TIMEOUT_EN
            timer_r     <= timer_nxt_s;
`endif
        end
    end

    assign gnt     = gnt_r;
    assign ack     = ack_r;
    assign trmt    = trmt_r;
    assign busy    = busy_r;
    assign err     = err_r;
    assign tx_data = tx_data_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed latency/reset/abandon cases
// plus randomized packet mixes checked against a round-robin packet model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [8*N-1:0] din;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           trmt;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic           err;

    int total = 0;
    int bad   = 0;

    // packets presented by each requester (flattened byte lists)
    logic [7:0] pb_data [N][64];
    bit         pb_last [N][64];
    int         pb_n    [N];
    int         pb_pos  [N];
    bit         env_en;
    bit         tx_auto;
    int         tx_cnt;

    // monitor log and expected log
    int         log_idx  [256];
    logic [7:0] log_data [256];
    int         log_n;
    int         exp_idx  [256];
    logic [7:0] exp_data [256];
    int         exp_n;
    int         trmt_cnt, rise_cnt, consec_cnt, ack_bad_cnt;
    bit         prev_trmt;

    uart_tx_arb #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .din     (din),
        .ack     (ack),
        .gnt     (gnt),
        .busy    (busy),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One cycle: sample at negedge, then advance transmitter and requesters.
    task automatic tick();
        @(negedge clk);
        if (trmt === 1'b1) begin
            if (prev_trmt) consec_cnt++;
            if (!$onehot(ack) || ack !== gnt) ack_bad_cnt++;
            log_idx[log_n]  = oh_idx(ack);
            log_data[log_n] = tx_data;
            log_n++;
            trmt_cnt++;
        end
        prev_trmt = (trmt === 1'b1);
        if (tx_auto) begin
            if (trmt === 1'b1) begin
                tx_done = 1'b0;
                tx_cnt  = $urandom_range(2, 6);
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    rise_cnt++;
                end
            end
        end
        if (env_en) begin
            for (int i = 0; i < N; i++) begin
                if (ack[i] === 1'b1) pb_pos[i]++;
                if (pb_pos[i] < pb_n[i]) begin
                    req[i]        = 1'b1;
                    last[i]       = pb_last[i][pb_pos[i]];
                    din[i*8 +: 8] = pb_data[i][pb_pos[i]];
                end else begin
                    req[i]        = 1'b0;
                    last[i]       = 1'($urandom);
                    din[i*8 +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic do_reset();
        env_en  = 1'b0;
        tx_auto = 1'b0;
        tx_done = 1'b0;
        tx_cnt  = 0;
        req     = '0;
        last    = '0;
        din     = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            pb_n[i]   = 0;
            pb_pos[i] = 0;
        end
        log_n = 0; trmt_cnt = 0; rise_cnt = 0; consec_cnt = 0; ack_bad_cnt = 0;
        prev_trmt = 1'b0;
    endtask

    // Run until every queued byte is sent and the arbiter is idle.
    task automatic wait_idle(input int budget, output bit ok);
        bit all_done;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            all_done = (busy === 1'b0);
            for (int i = 0; i < N; i++) if (pb_pos[i] < pb_n[i]) all_done = 1'b0;
            if (all_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Packet-level reference: after each packet, the next requester above the
    // previous owner (wrapping) that still has packets sends its whole packet.
    task automatic build_expected();
        int  ptr;
        int  pick;
        int  pos [N];
        bit  more;
        ptr   = N - 1;
        exp_n = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        more = 1'b1;
        while (more) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (pick < 0 && pos[c] < pb_n[c]) pick = c;
            end
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    exp_idx[exp_n]  = pick;
                    exp_data[exp_n] = pb_data[pick][pos[pick]];
                    exp_n++;
                    pos[pick]++;
                end while (!pb_last[pick][pos[pick]-1]);
                ptr = pick;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 4'b1111;
        last    = 4'b1111;
        din     = 32'hDEADBEEF;
        tx_done = 1'b1;
        tick();
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        total++; if (trmt !== 1'b0) begin bad++; $display("FAIL reset_trmt: got %b want 0", trmt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
    endtask

    task automatic test_single_byte();
        do_reset();
        req = 4'b0001; last = 4'b0001; din = 32'h000000A5;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sb_gnt_c1: got %b want 0001", gnt); end
        total++; if (trmt !== 1'b0) begin bad++; $display("FAIL sb_trmt_c1: got %b want 0", trmt); end
        tick();
        total++; if (trmt !== 1'b1) begin bad++; $display("FAIL sb_trmt_c2: got %b want 1", trmt); end
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL sb_ack_c2: got %b want 0001", ack); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL sb_data_c2: got %h want a5", tx_data); end
        req = 4'b0000;
        din = 32'h0000005A;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (trmt !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0001) begin
                bad++; $display("FAIL sb_wait: got trmt=%b busy=%b gnt=%b want 0 1 0001", trmt, busy, gnt);
            end
        end
        tx_done = 1'b1;
        tick();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL sb_release: got gnt=%b busy=%b want 0000 0", gnt, busy);
        end
        tick();
        total++; if (trmt !== 1'b0 || busy !== 1'b0 || tx_data !== 8'hA5) begin
            bad++; $display("FAIL sb_after: got trmt=%b busy=%b data=%h want 0 0 a5", trmt, busy, tx_data);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int np, len, n;
        for (int r = 0; r < 5; r++) begin
            do_reset();
            if (r == 0) begin
                for (int i = 0; i < N; i++) begin
                    pb_data[i][0] = 8'(8'h10 + i);
                    pb_last[i][0] = 1'b1;
                    pb_n[i]       = 1;
                end
                pb_data[0][1] = 8'h14;
                pb_last[0][1] = 1'b1;
                pb_n[0]       = 2;
            end else begin
                for (int i = 0; i < N; i++) begin
                    np = $urandom_range(0, 3);
                    n  = 0;
                    for (int p = 0; p < np; p++) begin
                        len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) begin
                            pb_data[i][n] = 8'($urandom);
                            pb_last[i][n] = (b == len - 1);
                            n++;
                        end
                    end
                    pb_n[i] = n;
                end
            end
            build_expected();
            env_en  = 1'b1;
            tx_auto = 1'b1;
            wait_idle(2000, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_timeout: round %0d did not finish", r); end
            total++; if (log_n !== exp_n) begin bad++; $display("FAIL rr_count: got %0d want %0d", log_n, exp_n); end
            for (int k = 0; k < exp_n && k < log_n; k++) begin
                total++; if (log_idx[k] !== exp_idx[k] || log_data[k] !== exp_data[k]) begin
                    bad++; $display("FAIL rr_byte%0d: got req%0d/%h want req%0d/%h",
                                    k, log_idx[k], log_data[k], exp_idx[k], exp_data[k]);
                end
            end
            total++; if (consec_cnt !== 0) begin bad++; $display("FAIL rr_consec_trmt: got %0d want 0", consec_cnt); end
            total++; if (ack_bad_cnt !== 0) begin bad++; $display("FAIL rr_ack_gnt: got %0d want 0", ack_bad_cnt); end
            total++; if (trmt_cnt !== rise_cnt) begin bad++; $display("FAIL rr_trmt_per_done: got %0d want %0d", trmt_cnt, rise_cnt); end
        end
    endtask

    task automatic test_multibyte();
        bit         ok;
        int         xi [4];
        logic [7:0] xd [4];
        xi = '{2, 2, 2, 1};
        xd = '{8'h01, 8'h02, 8'h03, 8'hAB};
        do_reset();
        pb_data[2][0] = 8'h01; pb_last[2][0] = 1'b0;
        pb_data[2][1] = 8'h02; pb_last[2][1] = 1'b0;
        pb_data[2][2] = 8'h03; pb_last[2][2] = 1'b1;
        pb_n[2]  = 3;
        env_en   = 1'b1;
        tx_auto  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            tick();
            ok = (gnt === 4'b0100);
        end
        total++; if (!ok) begin bad++; $display("FAIL mb_grant2: got %b want 0100", gnt); end
        pb_data[1][0] = 8'hAB; pb_last[1][0] = 1'b1;
        pb_n[1] = 1;
        wait_idle(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL mb_timeout: not idle"); end
        total++; if (log_n !== 4) begin bad++; $display("FAIL mb_count: got %0d want 4", log_n); end
        for (int k = 0; k < 4 && k < log_n; k++) begin
            total++; if (log_idx[k] !== xi[k] || log_data[k] !== xd[k]) begin
                bad++; $display("FAIL mb_byte%0d: got req%0d/%h want req%0d/%h", k, log_idx[k], log_data[k], xi[k], xd[k]);
            end
        end
    endtask

    task automatic test_abandon();
        bit ok;
        do_reset();
        pb_data[1][0] = 8'h11; pb_last[1][0] = 1'b1; pb_n[1] = 1;
        env_en  = 1'b1;
        tx_auto = 1'b1;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL ab_setup: not idle"); end
        env_en = 1'b0;
        req = 4'b1000; last = 4'b1000; din = 32'h77000000;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL ab_gnt3: got %b want 1000", gnt); end
        req = 4'b0000;
        tick();
        total++; if (trmt !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL ab_drop: got trmt=%b ack=%b gnt=%b busy=%b want 0 0000 0000 0", trmt, ack, gnt, busy);
        end
        req = 4'b0101; last = 4'b0101;
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ab_next: got %b want 0001", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        do_reset();
        req = 4'b0001; last = 4'b0001; din = 32'h0000005A;
        tick();
        tick();
        total++; if (trmt !== 1'b1) begin bad++; $display("FAIL rw_trmt: got %b want 1", trmt); end
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (gnt !== 4'b0000 || ack !== 4'b0000 || trmt !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL rw_reset: got gnt=%b ack=%b trmt=%b busy=%b err=%b data=%h", gnt, ack, trmt, busy, err, tx_data);
        end
        tx_done = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (trmt !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rw_stray_done: got activity=1 want 0"); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010; last = 4'b0010; din = 32'h0000C300;
        tick();
        tick();
        total++; if (trmt !== 1'b1 || tx_data !== 8'hC3) begin
            bad++; $display("FAIL to_trmt: got trmt=%b data=%h want 1 c3", trmt, tx_data);
        end
        req = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef UART_ARB_TIMEOUT_EN
            total++; if (err !== (k == TO)) begin bad++; $display("FAIL to_err_k%0d: got %b want %b", k, err, (k == TO)); end
            if (k == TO) begin
                total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
                    bad++; $display("FAIL to_release: got gnt=%b busy=%b want 0000 0", gnt, busy);
                end
            end
`else
            total++; if (err !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0010) begin
                bad++; $display("FAIL to_hold_k%0d: got err=%b busy=%b gnt=%b want 0 1 0010", k, err, busy, gnt);
            end
`endif
        end
    endtask

    initial begin
        env_en = 1'b0; tx_auto = 1'b0; tx_cnt = 0;
        log_n = 0; trmt_cnt = 0; rise_cnt = 0; consec_cnt = 0; ack_bad_cnt = 0;
        prev_trmt = 1'b0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_multibyte();
        test_abandon();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
